// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment types, blank pattern and hex decode table
package seg7_pkg;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_OFF = 7'h00;
  function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: slot divider and digit index for the multiplexed scan
module scan_timer #(
  parameter int CLK_DIV = 50000,
  parameter int NUM_DIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  output logic [$clog2(CLK_DIV)-1:0] div_cnt,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] idx
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  // advance the slot counter and step to the next digit on wrap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt <= '0;
      idx <= '0;
    end else if (div_cnt == CW'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    end else
      div_cnt <= div_cnt + 1'b1;
endmodule

// File: rtl/hex_display_scan.sv
// hex_display_scan: static and time-multiplexed hex driver for a 7-segment bank
module hex_display_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit AN_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic load,
  input  logic lz_en,
  input  logic blank,
  output logic [7*NUM_DIGITS-1:0] seg_all,
  output logic [NUM_DIGITS-1:0] dp_all,
  output logic [6:0] seg,
  output logic dp,
  output logic [NUM_DIGITS-1:0] an
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam seg7_t SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic DP_INV = SEG_ACTIVE_LOW;
  localparam logic AN_INV = AN_ACTIVE_LOW;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0] dp_q;
  logic [CW-1:0] div_cnt;
  logic [IW-1:0] idx;
  logic [7*NUM_DIGITS-1:0] pat_all;
  logic [NUM_DIGITS-1:0] sel;
  logic any_nz;
  logic scan_on;
  scan_timer #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(NUM_DIGITS)) u_timer (
    .clk(clk),
    .rst(rst),
    .div_cnt(div_cnt),
    .idx(idx)
  );
  // shadow copy of the displayed value, replaced only on load
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      val_q <= '0;
      dp_q <= '0;
    end else if (load) begin
      val_q <= value;
      dp_q <= dp_mask;
    end
  // decode each digit; a running OR from the MSB down darkens leading zeros, digit 0 always shows
  always_comb begin
    any_nz = 1'b0;
    pat_all = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_nz = any_nz | (val_q[4*i+:4] != 4'h0);
      pat_all[7*i+:7] = (!lz_en || i == 0 || any_nz) ? hex_to_seg(val_q[4*i+:4]) : SEG_OFF;
    end
    sel = NUM_DIGITS'(1) << idx;
    scan_on = !blank && div_cnt >= CW'(BLANK_CYCLES);
  end
  // register both output forms with polarity applied; blanking window keeps anodes off at slot start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seg_all <= {NUM_DIGITS{SEG_INV}};
      dp_all <= {NUM_DIGITS{DP_INV}};
      seg <= SEG_INV;
      dp <= DP_INV;
      an <= {NUM_DIGITS{AN_INV}};
    end else begin
      seg_all <= (blank ? {NUM_DIGITS{SEG_OFF}} : pat_all) ^ {NUM_DIGITS{SEG_INV}};
      dp_all <= (blank ? '0 : dp_q) ^ {NUM_DIGITS{DP_INV}};
      seg <= (scan_on ? pat_all[7*idx+:7] : SEG_OFF) ^ SEG_INV;
      dp <= (scan_on & dp_q[idx]) ^ DP_INV;
      an <= (scan_on ? sel : '0) ^ {NUM_DIGITS{AN_INV}};
    end
endmodule
